hoplite_tx_assembler: RTL and testbench

HOPLITE_TX_ASSEMBLER -- requirements
Module: hoplite_tx_assembler

---
 rtl/hoplite_tx_assembler_pkg.sv | 17 +
 rtl/flit_fifo.sv | 50 +++++
 rtl/hoplite_tx_assembler.sv | 141 ++++++++++++++
 tb/tb_hoplite_tx_assembler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hoplite_tx_assembler_pkg.sv
// Shared types for the Hoplite transmit assembler: hold-stage states and flit layout.
package hoplite_tx_assembler_pkg;

  localparam int unsigned DataBits = 32;

  typedef enum logic [1:0] {
    HoldEmpty,
    HoldHeld,
    HoldHeldClose
  } hold_state_e;

  // Flits are packed MSB first as {last, y, x, data}.
  function automatic int unsigned flit_bits(int unsigned coord_bits);
    return 1 + 2 * coord_bits + DataBits;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through flit queue; a push into a full queue succeeds only alongside a pop.
module flit_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrBits = $clog2(Depth);

  logic [Width-1:0]   mem_q [Depth];
  logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrBits:0]   count_q;
  logic               do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrBits + 1)'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrBits'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrBits'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrBits + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PtrBits + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hoplite_tx_assembler.sv
// Turns CPU coordinate/word/complete writes into a stream of Hoplite flits for router injection.
module hoplite_tx_assembler
  import hoplite_tx_assembler_pkg::*;
#(
  parameter int unsigned COORD_BITS = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [COORD_BITS-1:0]         x_coord_in,
  input  logic                          x_coord_in_valid,
  input  logic [COORD_BITS-1:0]         y_coord_in,
  input  logic                          y_coord_in_valid,
  input  logic [31:0]                   message_in,
  input  logic                          message_in_valid,
  input  logic                          packet_in_complete,
  output logic                          flit_out_valid,
  output logic [COORD_BITS-1:0]         flit_out_x,
  output logic [COORD_BITS-1:0]         flit_out_y,
  output logic [31:0]                   flit_out_data,
  output logic                          flit_out_last,
  input  logic                          flit_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          orphan_complete,
  input  logic                          clear_errors,
  output logic                          busy
);

  localparam int unsigned FlitBits = flit_bits(COORD_BITS);

  hold_state_e           state_q, state_d;
  logic [31:0]           held_data_q, held_data_d;
  logic [COORD_BITS-1:0] held_x_q, held_x_d, held_y_q, held_y_d;
  logic [COORD_BITS-1:0] dest_x_q, dest_y_q;
  logic                  overflow_q, orphan_q;
  logic                  push, push_last, capture, orphan_set, overflow_set;
  logic                  pop, fifo_full, fifo_empty;
  logic [FlitBits-1:0]   push_flit, head_flit;

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_last  = 1'b0;
    capture    = 1'b0;
    orphan_set = 1'b0;
    unique case (state_q)
      HoldEmpty: begin
        if (message_in_valid) begin
          capture = 1'b1;
          state_d = packet_in_complete ? HoldHeldClose : HoldHeld;
        end else if (packet_in_complete) begin
          orphan_set = 1'b1;
        end
      end
      HoldHeld: begin
        if (message_in_valid) begin
          push    = 1'b1;
          capture = 1'b1;
          state_d = packet_in_complete ? HoldHeldClose : HoldHeld;
        end else if (packet_in_complete) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = HoldEmpty;
        end
      end
      HoldHeldClose: begin
        push      = 1'b1;
        push_last = 1'b1;
        if (message_in_valid) begin
          capture = 1'b1;
          state_d = packet_in_complete ? HoldHeldClose : HoldHeld;
        end else begin
          // The held word already closes its packet, so a bare complete here has no owner.
          orphan_set = packet_in_complete;
          state_d    = HoldEmpty;
        end
      end
      default: state_d = HoldEmpty;
    endcase
  end

  always_comb begin
    held_data_d = held_data_q;
    held_x_d    = held_x_q;
    held_y_d    = held_y_q;
    if (capture) begin
      held_data_d = message_in;
      held_x_d    = dest_x_q;
      held_y_d    = dest_y_q;
    end
  end

  assign push_flit    = {push_last, held_y_q, held_x_q, held_data_q};
  assign pop          = flit_out_valid && flit_out_ready;
  assign overflow_set = push && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HoldEmpty;
      held_data_q <= '0;
      held_x_q    <= '0;
      held_y_q    <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_data_q <= held_data_d;
      held_x_q    <= held_x_d;
      held_y_q    <= held_y_d;
      if (x_coord_in_valid) dest_x_q <= x_coord_in;
      if (y_coord_in_valid) dest_y_q <= y_coord_in;
      overflow_q  <= overflow_set | (overflow_q & ~clear_errors);
      orphan_q    <= orphan_set | (orphan_q & ~clear_errors);
    end
  end

  flit_fifo #(
    .Width (FlitBits),
    .Depth (FIFO_DEPTH)
  ) u_flit_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_flit),
    .pop       (pop),
    .pop_data  (head_flit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {flit_out_last, flit_out_y, flit_out_x, flit_out_data} = head_flit;
  assign flit_out_valid  = !fifo_empty;
  assign overflow        = overflow_q;
  assign orphan_complete = orphan_q;
  assign busy            = (state_q != HoldEmpty) || !fifo_empty;

endmodule

// File: tb/tb_hoplite_tx_assembler.sv
// Self-checking bench: directed scenarios plus randomized packets against a packet-level model.
module tb_hoplite_tx_assembler;

  localparam int CB    = 2;
  localparam int DEPTH = 8;
  localparam int FW    = 1 + 2 * CB + 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CB-1:0] x_coord_in, y_coord_in;
  logic          x_coord_in_valid, y_coord_in_valid;
  logic [31:0]   message_in;
  logic          message_in_valid, packet_in_complete;
  logic          flit_out_valid, flit_out_last, flit_out_ready;
  logic [CB-1:0] flit_out_x, flit_out_y;
  logic [31:0]   flit_out_data;
  logic [CW-1:0] fifo_count;
  logic          overflow, orphan_complete, clear_errors, busy;

  int passed = 0;
  int total  = 0;
  bit rand_ready = 1'b0;
  logic [FW-1:0] obs_q[$];

  hoplite_tx_assembler #(
    .COORD_BITS (CB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .x_coord_in         (x_coord_in),
    .x_coord_in_valid   (x_coord_in_valid),
    .y_coord_in         (y_coord_in),
    .y_coord_in_valid   (y_coord_in_valid),
    .message_in         (message_in),
    .message_in_valid   (message_in_valid),
    .packet_in_complete (packet_in_complete),
    .flit_out_valid     (flit_out_valid),
    .flit_out_x         (flit_out_x),
    .flit_out_y         (flit_out_y),
    .flit_out_data      (flit_out_data),
    .flit_out_last      (flit_out_last),
    .flit_out_ready     (flit_out_ready),
    .fifo_count         (fifo_count),
    .overflow           (overflow),
    .orphan_complete    (orphan_complete),
    .clear_errors       (clear_errors),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Every accepted flit, as {last, y, x, data}.
  always @(negedge clk) begin
    if (reset_n && flit_out_valid && flit_out_ready)
      obs_q.push_back({flit_out_last, flit_out_y, flit_out_x, flit_out_data});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    x_coord_in_valid   = 1'b0;
    y_coord_in_valid   = 1'b0;
    message_in_valid   = 1'b0;
    packet_in_complete = 1'b0;
    clear_errors       = 1'b0;
    if (rand_ready) flit_out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (flit_out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", flit_out_valid); else passed++;
    total++; if (fifo_count !== '0) $display("FAIL rst_count got %0d want 0", fifo_count); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if ({overflow, orphan_complete} !== 2'b00)
      $display("FAIL rst_errors got %b want 00", {overflow, orphan_complete}); else passed++;
    reset_n = 1'b1;
    cyc();
    total++; if (busy !== 1'b0) $display("FAIL rst_busy_after got %b want 0", busy); else passed++;
  endtask

  task automatic test_single();
    obs_q.delete();
    flit_out_ready = 1'b1;
    x_coord_in = 2'd1; x_coord_in_valid = 1'b1;
    y_coord_in = 2'd0; y_coord_in_valid = 1'b1;
    cyc();
    message_in = 32'hA5A5_0001; message_in_valid = 1'b1;
    cyc();
    total++; if (flit_out_valid !== 1'b0) $display("FAIL single_early got %b want 0", flit_out_valid); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passed++;
    packet_in_complete = 1'b1;
    cyc();
    total++; if (flit_out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", flit_out_valid); else passed++;
    total++; if ({flit_out_last, flit_out_y, flit_out_x, flit_out_data} !== {1'b1, 2'd0, 2'd1, 32'hA5A5_0001})
      $display("FAIL single_flit got %h want %h", {flit_out_last, flit_out_y, flit_out_x, flit_out_data},
               {1'b1, 2'd0, 2'd1, 32'hA5A5_0001}); else passed++;
    cyc();
    total++; if (flit_out_valid !== 1'b0) $display("FAIL single_popped got %b want 0", flit_out_valid); else passed++;
    total++; if (obs_q.size() != 1) $display("FAIL single_count got %0d want 1", obs_q.size()); else passed++;
  endtask

  task automatic test_multi_word();
    obs_q.delete();
    flit_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      message_in = 32'(i); message_in_valid = 1'b1;
      cyc();
    end
    packet_in_complete = 1'b1;
    cyc();
    repeat (4) cyc();
    total++; if (obs_q.size() != 3) $display("FAIL multi_size got %0d want 3", obs_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      total++;
      if ({obs_q[i][FW-1], obs_q[i][31:0]} !== {(i == 2), 32'(i + 1)})
        $display("FAIL multi_flit%0d got last=%b data=%h want last=%b data=%h", i, obs_q[i][FW-1],
                 obs_q[i][31:0], (i == 2), 32'(i + 1));
      else passed++;
    end
  endtask

  task automatic test_overflow();
    obs_q.delete();
    flit_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      message_in = 32'(32'h100 + i); message_in_valid = 1'b1; packet_in_complete = 1'b1;
      cyc();
    end
    cyc();
    total++; if (fifo_count !== CW'(DEPTH)) $display("FAIL ovf_count got %0d want %0d", fifo_count, DEPTH); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
    flit_out_ready = 1'b1;
    repeat (12) cyc();
    total++; if (obs_q.size() != DEPTH) $display("FAIL ovf_drained got %0d want %0d", obs_q.size(), DEPTH); else passed++;
    for (int i = 0; i < obs_q.size() && i < DEPTH; i++) begin
      total++;
      if ({obs_q[i][FW-1], obs_q[i][31:0]} !== {1'b1, 32'(32'h100 + i)})
        $display("FAIL ovf_flit%0d got last=%b data=%h want last=1 data=%h", i, obs_q[i][FW-1],
                 obs_q[i][31:0], 32'(32'h100 + i));
      else passed++;
    end
    clear_errors = 1'b1;
    cyc();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
  endtask

  task automatic test_orphan();
    obs_q.delete();
    flit_out_ready = 1'b1;
    packet_in_complete = 1'b1;
    cyc();
    total++; if (orphan_complete !== 1'b1) $display("FAIL orphan_set got %b want 1", orphan_complete); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL orphan_busy got %b want 0", busy); else passed++;
    repeat (3) cyc();
    total++; if (obs_q.size() != 0) $display("FAIL orphan_noflit got %0d want 0", obs_q.size()); else passed++;
    clear_errors = 1'b1; packet_in_complete = 1'b1;
    cyc();
    total++; if (orphan_complete !== 1'b1) $display("FAIL orphan_win got %b want 1", orphan_complete); else passed++;
    clear_errors = 1'b1;
    cyc();
    total++; if (orphan_complete !== 1'b0) $display("FAIL orphan_clear got %b want 0", orphan_complete); else passed++;
  endtask

  task automatic test_same_cycle_close();
    obs_q.delete();
    flit_out_ready = 1'b1;
    message_in = 32'h11; message_in_valid = 1'b1;
    cyc();
    message_in = 32'h22; message_in_valid = 1'b1; packet_in_complete = 1'b1;
    cyc();
    total++; if ({flit_out_valid, flit_out_last, flit_out_data} !== {2'b10, 32'h11})
      $display("FAIL close_first got %b/%b/%h want 1/0/11", flit_out_valid, flit_out_last, flit_out_data); else passed++;
    cyc();
    total++; if ({flit_out_valid, flit_out_last, flit_out_data} !== {2'b11, 32'h22})
      $display("FAIL close_second got %b/%b/%h want 1/1/22", flit_out_valid, flit_out_last, flit_out_data); else passed++;
    repeat (3) cyc();
    total++; if (obs_q.size() != 2) $display("FAIL close_size got %0d want 2", obs_q.size()); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    obs_q.delete();
    flit_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      message_in = 32'(32'h500 + i); message_in_valid = 1'b1; packet_in_complete = 1'b1;
      cyc();
    end
    message_in = 32'h999; message_in_valid = 1'b1;
    cyc();
    total++; if (fifo_count !== CW'(3)) $display("FAIL rmid_queued got %0d want 3", fifo_count); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if ({flit_out_valid, busy} !== 2'b00) $display("FAIL rmid_valid got %b want 00", {flit_out_valid, busy}); else passed++;
    total++; if (fifo_count !== '0) $display("FAIL rmid_count got %0d want 0", fifo_count); else passed++;
    cyc();
    reset_n = 1'b1;
    flit_out_ready = 1'b1;
    repeat (10) cyc();
    total++; if (obs_q.size() != 0) $display("FAIL rmid_noflit got %0d want 0", obs_q.size()); else passed++;
    message_in = 32'h77; message_in_valid = 1'b1; packet_in_complete = 1'b1;
    cyc();
    repeat (3) cyc();
    total++; if (obs_q.size() != 1) $display("FAIL rmid_after_size got %0d want 1", obs_q.size());
    else begin
      if (obs_q[0] !== {1'b1, 2'd0, 2'd0, 32'h77})
        $display("FAIL rmid_dest_reset got %h want %h", obs_q[0], {1'b1, 2'd0, 2'd0, 32'h77});
      else passed++;
    end
  endtask

  // Model: each packet is a list of words under one destination; the expected stream is the
  // words in order with last set on the final word of each packet.
  task automatic test_random_packets();
    logic [FW-1:0] exp_q[$];
    logic [CB-1:0] xv, yv;
    logic [31:0]   d;
    int            len, guard;
    bit            sep, last;
    obs_q.delete();
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      xv = CB'($urandom); yv = CB'($urandom);
      x_coord_in = xv; x_coord_in_valid = 1'b1;
      y_coord_in = yv; y_coord_in_valid = 1'b1;
      cyc();
      len = $urandom_range(4, 1);
      sep = 1'($urandom_range(1));
      for (int w = 0; w < len; w++) begin
        guard = 0;
        while (fifo_count >= CW'(5) && guard < 100) begin
          cyc();
          guard++;
        end
        if (guard >= 100) begin
          total++;
          $display("FAIL rand_stall got count=%0d want below 5", fifo_count);
        end
        d    = $urandom;
        last = (w == len - 1);
        message_in = d; message_in_valid = 1'b1;
        if (last && !sep) packet_in_complete = 1'b1;
        exp_q.push_back({last, yv, xv, d});
        cyc();
        if ($urandom_range(3) == 0) cyc();
      end
      if (sep) begin
        packet_in_complete = 1'b1;
        cyc();
      end
    end
    rand_ready = 1'b0;
    flit_out_ready = 1'b1;
    guard = 0;
    while ((obs_q.size() < exp_q.size() || busy) && guard < 200) begin
      cyc();
      guard++;
    end
    total++; if (obs_q.size() != exp_q.size())
      $display("FAIL rand_size got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_flit%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++; if ({overflow, orphan_complete} !== 2'b00)
      $display("FAIL rand_errors got %b want 00", {overflow, orphan_complete}); else passed++;
  endtask

  initial begin
    reset_n = 1'b0;
    x_coord_in = '0; y_coord_in = '0; message_in = '0;
    x_coord_in_valid = 1'b0; y_coord_in_valid = 1'b0; message_in_valid = 1'b0;
    packet_in_complete = 1'b0; clear_errors = 1'b0; flit_out_ready = 1'b0;
    test_reset();
    test_single();
    test_multi_word();
    test_overflow();
    test_orphan();
    test_same_cycle_close();
    test_reset_mid_packet();
    test_random_packets();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
